// File: rtl/ahb_lite_1xn_dec_if.sv
// ----------------------------------------------------------------------------
// ahb_lite_1xn_dec_if
// Bundle of every AHB-Lite signal around the 1-master/N-slave fabric. It holds
// the upstream link to the core master (s_*) and the broadcast links to the
// N slave ports (m_*). The per-port signals are packed arrays indexed by port.
//
// Modports
//   slave  : the fabric's view. It receives the master request and the slave
//            responses, and drives the master response and the per-port
//            request/select signals.
//   master : the surrounding system's view (core master plus slave models).
//            It has the opposite directions.
// ----------------------------------------------------------------------------
interface ahb_lite_1xn_dec_if #(
    parameter int HDATA_WIDTH = 64,
    parameter int HADDR_WIDTH = 17,
    parameter int HPORT_COUNT = 2
);
    // Upstream master request
    logic [HADDR_WIDTH-1:0]                  s_HADDR;
    logic [1:0]                              s_HTRANS;
    logic [2:0]                              s_HSIZE;
    logic                                    s_HWRITE;
    logic [HDATA_WIDTH-1:0]                  s_HWDATA;

    // Upstream response back to the master
    logic [HDATA_WIDTH-1:0]                  s_HRDATA;
    logic                                    s_HREADY;
    logic                                    s_HRESP;

    // Broadcast request to each slave port
    logic [HPORT_COUNT-1:0][HADDR_WIDTH-1:0] m_HADDR;
    logic [HPORT_COUNT-1:0][1:0]             m_HTRANS;
    logic [HPORT_COUNT-1:0][2:0]             m_HSIZE;
    logic [HPORT_COUNT-1:0]                  m_HWRITE;
    logic [HPORT_COUNT-1:0][HDATA_WIDTH-1:0] m_HWDATA;
    logic [HPORT_COUNT-1:0]                  m_HSEL;
    logic [HPORT_COUNT-1:0]                  m_HREADY;

    // Responses from each slave port
    logic [HPORT_COUNT-1:0][HDATA_WIDTH-1:0] m_HRDATA;
    logic [HPORT_COUNT-1:0]                  m_HRESP;
    logic [HPORT_COUNT-1:0]                  m_HREADYOUT;

    modport slave (
        input  s_HADDR, s_HTRANS, s_HSIZE, s_HWRITE, s_HWDATA,
        output s_HRDATA, s_HREADY, s_HRESP,
        output m_HADDR, m_HTRANS, m_HSIZE, m_HWRITE, m_HWDATA, m_HSEL, m_HREADY,
        input  m_HRDATA, m_HRESP, m_HREADYOUT
    );

    modport master (
        output s_HADDR, s_HTRANS, s_HSIZE, s_HWRITE, s_HWDATA,
        input  s_HRDATA, s_HREADY, s_HRESP,
        input  m_HADDR, m_HTRANS, m_HSIZE, m_HWRITE, m_HWDATA, m_HSEL, m_HREADY,
        output m_HRDATA, m_HRESP, m_HREADYOUT
    );
endinterface

// File: rtl/ahb_lite_1xn_dec.sv
// ----------------------------------------------------------------------------
// ahb_lite_1xn_dec
// AHB-Lite fabric that connects one master to N slaves. It contains:
//   - an address decoder that compares against a BASE/MASK pair for each port,
//   - a default slave that returns a 2-cycle ERROR for unmapped NONSEQ/SEQ
//     transfers,
//   - a watchdog for hung slaves. When a data phase stalls for TIMEOUT cycles,
//     the watchdog ends it with ERROR and fences that port off until the slave
//     raises HREADYOUT again.
// On mapped paths the fabric adds no wait states.
//
// Ports
//   HCLK, HRESET   clock and asynchronous active-high reset
//   bus            ahb_lite_1xn_dec_if.slave, which carries the master link
//                  (s_*) and the N slave links (m_*)
//   hung           per-port flag, set while that port is fenced after a timeout
//   err_unmapped   1-cycle pulse during the first ERROR cycle of an unmapped
//                  access
//   err_timeout    1-cycle pulse during the first ERROR cycle of a watchdog
//                  abort
// ----------------------------------------------------------------------------
module ahb_lite_1xn_dec #(
    parameter int HDATA_WIDTH = 64,
    parameter int HADDR_WIDTH = 17,
    parameter int HPORT_COUNT = 2,
    parameter logic [HPORT_COUNT-1:0][HADDR_WIDTH-1:0] PORT_BASE = {17'h10000, 17'h00000},
    parameter logic [HPORT_COUNT-1:0][HADDR_WIDTH-1:0] PORT_MASK = {17'h18000, 17'h18000},
    parameter int TIMEOUT     = 256
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    ahb_lite_1xn_dec_if.slave      bus,
    output logic [HPORT_COUNT-1:0] hung,
    output logic                   err_unmapped,
    output logic                   err_timeout
);

    localparam int PW     = (HPORT_COUNT > 1) ? $clog2(HPORT_COUNT) : 1;
    localparam int WCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = (TIMEOUT > 0) ? WCNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        DP_NONE = 2'd0,
        DP_PORT = 2'd1,
        ERR1    = 2'd2,
        ERR2    = 2'd3
    } dpState_e;

    dpState_e               state_q, state_d;
    logic [PW-1:0]          port_q, port_d;
    logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
    logic [HPORT_COUNT-1:0] hung_q, hung_d;
    logic                   errTimeout_q, errTimeout_d;

    logic [PW-1:0]          winIdx;
    logic                   winValid;
    logic                   mapped;
    logic [HPORT_COUNT-1:0] sel;
    logic                   accept;
    logic                   sReady;
    logic                   sResp;
    logic [HDATA_WIDTH-1:0] sRdata;

    // The request wires go to every port unchanged. Only HSEL picks the target.
    assign bus.m_HADDR  = {HPORT_COUNT{bus.s_HADDR}};
    assign bus.m_HTRANS = {HPORT_COUNT{bus.s_HTRANS}};
    assign bus.m_HSIZE  = {HPORT_COUNT{bus.s_HSIZE}};
    assign bus.m_HWRITE = {HPORT_COUNT{bus.s_HWRITE}};
    assign bus.m_HWDATA = {HPORT_COUNT{bus.s_HWDATA}};

    // Address decoder. The loop scans from the highest index down, so on
    // overlapping windows the lowest matching index ends up as the winner.
    // A winner that is fenced counts as unmapped, so the default slave
    // answers in its place.
    always_comb begin
        winIdx   = '0;
        winValid = 1'b0;
        for (int i = HPORT_COUNT - 1; i >= 0; i--) begin
            if ((bus.s_HADDR & PORT_MASK[i]) == PORT_BASE[i]) begin
                winIdx   = PW'(i);
                winValid = 1'b1;
            end
        end
        mapped = winValid && !hung_q[winIdx];
        sel    = '0;
        if (mapped) begin
            sel[winIdx] = 1'b1;
        end
    end

    assign bus.m_HSEL = sel;

    // A fenced slave sees its own HREADYOUT as HREADY, so it can finish its
    // abandoned transfer without holding up the rest of the bus.
    assign bus.m_HREADY = (hung_q & bus.m_HREADYOUT) | (~hung_q & {HPORT_COUNT{sReady}});

    // Data-phase FSM. This block computes the next state and the upstream
    // response. A new address phase is taken in any cycle where the master
    // sees HREADY high: in DP_NONE, in ERR2, or on the final cycle of a port
    // data phase.
    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        wcnt_d       = '0;
        errTimeout_d = errTimeout_q;
        hung_d       = hung_q & ~bus.m_HREADYOUT;
        sReady       = 1'b1;
        sResp        = 1'b0;
        sRdata       = '0;
        accept       = 1'b0;

        case (state_q)
            DP_NONE: begin
                accept = 1'b1;
            end
            DP_PORT: begin
                sRdata = bus.m_HRDATA[port_q];
                sReady = bus.m_HREADYOUT[port_q];
                sResp  = bus.m_HRESP[port_q];
                // If the slave becomes ready in the threshold cycle, the
                // transfer completes normally and no timeout is raised.
                if (bus.m_HREADYOUT[port_q]) begin
                    accept = 1'b1;
                end else if ((TIMEOUT != 0) && (wcnt_q == WCNT_LAST)) begin
                    state_d         = ERR1;
                    errTimeout_d    = 1'b1;
                    hung_d[port_q]  = 1'b1;
                end else begin
                    wcnt_d = (wcnt_q == '1) ? wcnt_q : wcnt_q + 1'b1;
                end
            end
            ERR1: begin
                sReady  = 1'b0;
                sResp   = 1'b1;
                state_d = ERR2;
            end
            ERR2: begin
                sResp  = 1'b1;
                accept = 1'b1;
            end
            default: begin
                state_d = DP_NONE;
            end
        endcase

        // Choose the next data phase from the address phase accepted this cycle.
        if (accept) begin
            if (mapped) begin
                state_d = DP_PORT;
                port_d  = winIdx;
            end else if (bus.s_HTRANS[1]) begin
                state_d      = ERR1;
                errTimeout_d = 1'b0;
            end else begin
                state_d = DP_NONE;
            end
        end
    end

    // State registers. Reset drops any transfer in flight and clears all
    // fences.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q      <= DP_NONE;
            port_q       <= '0;
            wcnt_q       <= '0;
            hung_q       <= '0;
            errTimeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            wcnt_q       <= wcnt_d;
            hung_q       <= hung_d;
            errTimeout_q <= errTimeout_d;
        end
    end

    assign bus.s_HREADY = sReady;
    assign bus.s_HRESP  = sResp;
    assign bus.s_HRDATA = sRdata;

    assign hung         = hung_q;
    assign err_unmapped = (state_q == ERR1) && !errTimeout_q;
    assign err_timeout  = (state_q == ERR1) && errTimeout_q;

endmodule

// File: tb/tb_ahb_lite_1xn_dec.sv
// ----------------------------------------------------------------------------
// tb_ahb_lite_1xn_dec
// Directed testbench for the 1xN AHB-Lite fabric, built with TIMEOUT=8.
// The bench acts as both the core master and the two slave models.
// Each directed step below drives inputs, then compares the fabric's
// outputs with hand-computed values.
// ----------------------------------------------------------------------------
module tb_ahb_lite_1xn_dec;

    localparam int DW = 64;
    localparam int AW = 17;
    localparam int NP = 2;
    localparam logic [1:0]    HT_IDLE   = 2'b00;
    localparam logic [1:0]    HT_NONSEQ = 2'b10;
    localparam logic [AW-1:0] HOLE      = 17'h08000;

    logic          HCLK;
    logic          HRESET;
    logic [NP-1:0] hung;
    logic          errUnmapped;
    logic          errTimeout;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    ahb_lite_1xn_dec_if #(.HDATA_WIDTH(DW), .HADDR_WIDTH(AW), .HPORT_COUNT(NP)) bus ();

    ahb_lite_1xn_dec #(
        .HDATA_WIDTH(DW),
        .HADDR_WIDTH(AW),
        .HPORT_COUNT(NP),
        .TIMEOUT(8)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .bus         (bus.slave),
        .hung        (hung),
        .err_unmapped(errUnmapped),
        .err_timeout (errTimeout)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Advance one clock edge. Inputs change and checks happen just after it.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Drive the master's address-phase request.
    task automatic applyStimulus(input logic [AW-1:0] addr, input logic [1:0] trans,
                                 input logic write, input logic [DW-1:0] wdata);
        bus.s_HADDR  = addr;
        bus.s_HTRANS = trans;
        bus.s_HSIZE  = 3'b011;
        bus.s_HWRITE = write;
        bus.s_HWDATA = wdata;
        #1;
    endtask

    // Drive one slave model's response.
    task automatic setSlave(input int p, input logic ready, input logic [DW-1:0] rdata);
        bus.m_HREADYOUT[p] = ready;
        bus.m_HRDATA[p]    = rdata;
        bus.m_HRESP[p]     = 1'b0;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        HRESET           = 1'b1;
        bus.s_HADDR      = HOLE;
        bus.s_HTRANS     = HT_IDLE;
        bus.s_HSIZE      = 3'b011;
        bus.s_HWRITE     = 1'b0;
        bus.s_HWDATA     = '0;
        bus.m_HREADYOUT  = 2'b11;
        bus.m_HRESP      = 2'b00;
        bus.m_HRDATA[0]  = 64'h0A0A;
        bus.m_HRDATA[1]  = 64'h1B1B;
        repeat (2) tick();

        // Reset state
        checkOutput("rst_hready", 64'(bus.s_HREADY), 64'd1);
        checkOutput("rst_hresp",  64'(bus.s_HRESP),  64'd0);
        checkOutput("rst_hrdata", bus.s_HRDATA,      64'd0);
        checkOutput("rst_hung",   64'(hung),         64'd0);
        checkOutput("rst_err_u",  64'(errUnmapped),  64'd0);
        HRESET = 1'b0;
        tick();

        // Port1 read with two wait states
        setSlave(1, 1'b0, 64'h1B1B);
        applyStimulus(17'h10040, HT_NONSEQ, 1'b0, '0);
        checkOutput("t2_hsel",        64'(bus.m_HSEL),    64'h2);
        checkOutput("t2_haddr_bcast", 64'(bus.m_HADDR[0]), 64'h10040);
        checkOutput("t2_addr_hready", 64'(bus.s_HREADY),  64'd1);
        tick();
        applyStimulus(HOLE, HT_IDLE, 1'b0, '0);
        checkOutput("t2_wait1", 64'(bus.s_HREADY), 64'd0);
        tick();
        checkOutput("t2_wait2", 64'(bus.s_HREADY), 64'd0);
        tick();
        setSlave(1, 1'b1, 64'hDEADBEEF);
        checkOutput("t2_done_hready", 64'(bus.s_HREADY), 64'd1);
        checkOutput("t2_hrdata",      bus.s_HRDATA,      64'hDEADBEEF);
        checkOutput("t2_hresp",       64'(bus.s_HRESP),  64'd0);
        tick();
        checkOutput("t2_after_hrdata", bus.s_HRDATA, 64'd0);

        // Unmapped NONSEQ write, then IDLE to the same hole
        applyStimulus(HOLE, HT_NONSEQ, 1'b1, 64'h1234);
        checkOutput("t3_hsel", 64'(bus.m_HSEL), 64'd0);
        tick();
        applyStimulus(HOLE, HT_IDLE, 1'b0, '0);
        checkOutput("t3_err1_hready", 64'(bus.s_HREADY), 64'd0);
        checkOutput("t3_err1_hresp",  64'(bus.s_HRESP),  64'd1);
        checkOutput("t3_err_unmapped", 64'(errUnmapped), 64'd1);
        checkOutput("t3_err1_timeout", 64'(errTimeout),  64'd0);
        checkOutput("t3_err1_hrdata", bus.s_HRDATA,      64'd0);
        tick();
        checkOutput("t3_err2_hready", 64'(bus.s_HREADY), 64'd1);
        checkOutput("t3_err2_hresp",  64'(bus.s_HRESP),  64'd1);
        checkOutput("t3_err2_pulse",  64'(errUnmapped),  64'd0);
        tick();
        checkOutput("t3_idle_hready", 64'(bus.s_HREADY), 64'd1);
        checkOutput("t3_idle_hresp",  64'(bus.s_HRESP),  64'd0);

        // Port0 hangs: watchdog fires after 8 stall cycles
        setSlave(0, 1'b0, 64'h0A0A);
        applyStimulus(17'h00020, HT_NONSEQ, 1'b0, '0);
        checkOutput("t4_hsel", 64'(bus.m_HSEL), 64'h1);
        tick();
        applyStimulus(HOLE, HT_IDLE, 1'b0, '0);
        for (int k = 1; k <= 8; k++) begin
            checkOutput($sformatf("t4_stall%0d", k), 64'(bus.s_HREADY), 64'd0);
            tick();
        end
        checkOutput("t4_err1_hready",  64'(bus.s_HREADY), 64'd0);
        checkOutput("t4_err1_hresp",   64'(bus.s_HRESP),  64'd1);
        checkOutput("t4_err_timeout",  64'(errTimeout),   64'd1);
        checkOutput("t4_err1_unmapped", 64'(errUnmapped), 64'd0);
        checkOutput("t4_hung_set",     64'(hung),         64'h1);
        tick();
        checkOutput("t4_err2_hready",  64'(bus.s_HREADY), 64'd1);
        checkOutput("t4_err2_hresp",   64'(bus.s_HRESP),  64'd1);
        checkOutput("t4_err2_pulse",   64'(errTimeout),   64'd0);
        applyStimulus(17'h00010, HT_NONSEQ, 1'b0, '0);
        checkOutput("t4_fenced_hsel", 64'(bus.m_HSEL), 64'd0);
        tick();
        applyStimulus(HOLE, HT_IDLE, 1'b0, '0);
        checkOutput("t4_fenced_hresp",    64'(bus.s_HRESP),     64'd1);
        checkOutput("t4_fenced_err_u",    64'(errUnmapped),     64'd1);
        checkOutput("t4_fenced_mhready0", 64'(bus.m_HREADY[0]), 64'd0);
        tick();
        tick();
        setSlave(0, 1'b1, 64'h0A0A);
        checkOutput("t4_hung_hold",       64'(hung),            64'h1);
        checkOutput("t4_mhready0_follow", 64'(bus.m_HREADY[0]), 64'd1);
        tick();
        checkOutput("t4_hung_clear", 64'(hung), 64'd0);

        // Port0 ready exactly at the threshold cycle: normal completion
        setSlave(0, 1'b0, 64'h5555);
        applyStimulus(17'h00030, HT_NONSEQ, 1'b0, '0);
        tick();
        applyStimulus(HOLE, HT_IDLE, 1'b0, '0);
        for (int k = 1; k <= 7; k++) begin
            checkOutput($sformatf("t5_stall%0d", k), 64'(bus.s_HREADY), 64'd0);
            tick();
        end
        setSlave(0, 1'b1, 64'h5555);
        checkOutput("t5_hready",      64'(bus.s_HREADY), 64'd1);
        checkOutput("t5_hresp",       64'(bus.s_HRESP),  64'd0);
        checkOutput("t5_hrdata",      bus.s_HRDATA,      64'h5555);
        checkOutput("t5_err_timeout", 64'(errTimeout),   64'd0);
        tick();
        checkOutput("t5_hung",        64'(hung),         64'd0);
        checkOutput("t5_after_pulse", 64'(errTimeout),   64'd0);
        checkOutput("t5_idle_hready", 64'(bus.s_HREADY), 64'd1);

        // Pipelined reads: port0 (one wait state) then port1
        setSlave(0, 1'b0, 64'hA0);
        setSlave(1, 1'b1, 64'hB1);
        applyStimulus(17'h00100, HT_NONSEQ, 1'b0, '0);
        checkOutput("t6_hsel0", 64'(bus.m_HSEL), 64'h1);
        tick();
        applyStimulus(17'h10100, HT_NONSEQ, 1'b0, '0);
        checkOutput("t6_stall_hready", 64'(bus.s_HREADY),   64'd0);
        checkOutput("t6_hsel1",        64'(bus.m_HSEL),     64'h2);
        checkOutput("t6_mhready1",     64'(bus.m_HREADY[1]), 64'd0);
        tick();
        setSlave(0, 1'b1, 64'hA0);
        checkOutput("t6_p0_hready",   64'(bus.s_HREADY),    64'd1);
        checkOutput("t6_p0_hrdata",   bus.s_HRDATA,         64'hA0);
        checkOutput("t6_mhready1_go", 64'(bus.m_HREADY[1]), 64'd1);
        tick();
        applyStimulus(HOLE, HT_IDLE, 1'b0, '0);
        checkOutput("t6_p1_hrdata", bus.s_HRDATA,      64'hB1);
        checkOutput("t6_p1_hready", 64'(bus.s_HREADY), 64'd1);
        tick();
        checkOutput("t6_end_hrdata", bus.s_HRDATA, 64'd0);

        // Fence port1, start a stalled port0 phase, then reset mid-transfer
        setSlave(1, 1'b0, 64'h1B1B);
        applyStimulus(17'h10040, HT_NONSEQ, 1'b0, '0);
        tick();
        applyStimulus(HOLE, HT_IDLE, 1'b0, '0);
        repeat (8) tick();
        checkOutput("t1_pre_hung", 64'(hung), 64'h2);
        tick();
        setSlave(0, 1'b0, 64'h0A0A);
        applyStimulus(17'h00200, HT_NONSEQ, 1'b0, '0);
        tick();
        applyStimulus(HOLE, HT_IDLE, 1'b0, '0);
        checkOutput("t1_pre_hready", 64'(bus.s_HREADY), 64'd0);
        HRESET = 1'b1;
        #1;
        checkOutput("t1_hready",      64'(bus.s_HREADY), 64'd1);
        checkOutput("t1_hresp",       64'(bus.s_HRESP),  64'd0);
        checkOutput("t1_hrdata",      bus.s_HRDATA,      64'd0);
        checkOutput("t1_hung",        64'(hung),         64'd0);
        checkOutput("t1_err_timeout", 64'(errTimeout),   64'd0);
        HRESET = 1'b0;
        tick();
        checkOutput("t1_post_hready", 64'(bus.s_HREADY), 64'd1);
        checkOutput("t1_post_hresp",  64'(bus.s_HRESP),  64'd0);
        checkOutput("t1_post_hung",   64'(hung),         64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
